// File: rtl/orbit_pkg.sv
`default_nettype none
// ============================================================================
// Module  : orbit_pkg
// Purpose : Shared widths, background colour and scheduler state encoding.
// Revision: 1.0
// ============================================================================
package orbit_pkg;

  localparam int X_W_DEF     = 10;
  localparam int Y_W_DEF     = 9;
  localparam int COLOR_W_DEF = 8;

  localparam logic [7:0] BG_COLOR = 8'h00;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PICK  = 3'd1,
    ERASE = 3'd2,
    DRAW  = 3'd3,
    DONE  = 3'd4
  } state_e;

endpackage
`default_nettype wire

// File: rtl/orbit_frame_scheduler_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : rr_arbiter
// Purpose : Combinational round-robin pick: lowest requester at or above the
//           pointer, wrapping to the lowest requester overall.
// Revision: 1.0
// ============================================================================
module rr_arbiter #(
  parameter int N     = 4,
  parameter int PTR_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] pointer,
  output logic [N-1:0]     grant_idx,
  output logic             valid
);

  logic [N-1:0] masked;

  always_comb begin
    masked = '0;
    for (int i = 0; i < N; i++) begin
      masked[i] = req[i] && (i >= int'(pointer));
    end
  end

  // x & -x isolates the lowest set bit
  always_comb begin
    valid = |req;
    if (|masked) begin
      grant_idx = masked & (~masked + N'(1));
    end else begin
      grant_idx = req & (~req + N'(1));
    end
  end

endmodule
`default_nettype wire

// File: rtl/orbit_frame_scheduler.sv
`default_nettype none
// ============================================================================
// Module  : orbit_frame_scheduler
// Purpose : Shares one framebuffer write port between N object generators;
//           per object erases the old pixel then draws the new one in vblank.
//           Optional OVERRUN_CNT_EN adds a saturating overrun_cnt output.
// Revision: 1.0
// ============================================================================
module orbit_frame_scheduler
  import orbit_pkg::*;
#(
  parameter int N_OBJ   = 4,
  parameter int X_W     = X_W_DEF,
  parameter int Y_W     = Y_W_DEF,
  parameter int COLOR_W = COLOR_W_DEF
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       vblank,
  output logic                       step_en,
  input  logic [N_OBJ-1:0]           req,
  input  logic [N_OBJ*X_W-1:0]       req_x,
  input  logic [N_OBJ*Y_W-1:0]       req_y,
  input  logic [N_OBJ*COLOR_W-1:0]   req_color,
  output logic [N_OBJ-1:0]           grant,
  output logic                       wr_en,
  input  logic                       wr_ready,
  output logic [X_W-1:0]             wr_x,
  output logic [Y_W-1:0]             wr_y,
  output logic [COLOR_W-1:0]         wr_color,
  output logic                       busy
`ifdef OVERRUN_CNT_EN
  ,
  output logic [7:0]                 overrun_cnt
`endif
);

  localparam int PTR_W = (N_OBJ > 1) ? $clog2(N_OBJ) : 1;

  state_e               state_q, state_d;
  logic [PTR_W-1:0]     ptr_q, ptr_d;
  logic [PTR_W-1:0]     idx_q, idx_d;
  logic [X_W-1:0]       cur_x_q, cur_x_d;
  logic [Y_W-1:0]       cur_y_q, cur_y_d;
  logic [COLOR_W-1:0]   cur_c_q, cur_c_d;
  logic [X_W-1:0]       last_x_q [N_OBJ];
  logic [X_W-1:0]       last_x_d [N_OBJ];
  logic [Y_W-1:0]       last_y_q [N_OBJ];
  logic [Y_W-1:0]       last_y_d [N_OBJ];
  logic [N_OBJ-1:0]     last_valid_q, last_valid_d;
  logic                 vblank_q, vblank_d;
  logic                 step_en_q, step_en_d;

  logic [N_OBJ-1:0]     arb_grant;
  logic                 arb_valid;
  logic [PTR_W-1:0]     sel_idx;
  logic [X_W-1:0]       sel_x;
  logic [Y_W-1:0]       sel_y;
  logic [COLOR_W-1:0]   sel_c;
  logic                 sel_erase;
  logic [N_OBJ-1:0]     done_onehot;

  rr_arbiter #(
    .N     (N_OBJ),
    .PTR_W (PTR_W)
  ) u_rr_arbiter (
    .req       (req),
    .pointer   (ptr_q),
    .grant_idx (arb_grant),
    .valid     (arb_valid)
  );

  always_comb begin
    sel_idx   = '0;
    sel_x     = '0;
    sel_y     = '0;
    sel_c     = '0;
    sel_erase = 1'b0;
    for (int i = 0; i < N_OBJ; i++) begin
      if (arb_grant[i]) begin
        sel_idx   = PTR_W'(i);
        sel_x     = req_x[i*X_W +: X_W];
        sel_y     = req_y[i*Y_W +: Y_W];
        sel_c     = req_color[i*COLOR_W +: COLOR_W];
        sel_erase = last_valid_q[i] &&
                    ((last_x_q[i] != req_x[i*X_W +: X_W]) ||
                     (last_y_q[i] != req_y[i*Y_W +: Y_W]));
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    idx_d        = idx_q;
    cur_x_d      = cur_x_q;
    cur_y_d      = cur_y_q;
    cur_c_d      = cur_c_q;
    last_x_d     = last_x_q;
    last_y_d     = last_y_q;
    last_valid_d = last_valid_q;
    vblank_d     = vblank;
    step_en_d    = vblank && !vblank_q;
    grant        = '0;
    wr_en        = 1'b0;
    wr_x         = '0;
    wr_y         = '0;
    wr_color     = '0;
    done_onehot  = N_OBJ'(1) << idx_q;

    case (state_q)
      IDLE: begin
        if (vblank && (|req)) state_d = PICK;
      end
      PICK: begin
        if (arb_valid) begin
          idx_d   = sel_idx;
          cur_x_d = sel_x;
          cur_y_d = sel_y;
          cur_c_d = sel_c;
          state_d = sel_erase ? ERASE : DRAW;
        end else begin
          state_d = IDLE;
        end
      end
      ERASE: begin
        wr_en    = 1'b1;
        wr_x     = last_x_q[idx_q];
        wr_y     = last_y_q[idx_q];
        wr_color = COLOR_W'(BG_COLOR);
        if (wr_ready) state_d = DRAW;
      end
      DRAW: begin
        wr_en    = 1'b1;
        wr_x     = cur_x_q;
        wr_y     = cur_y_q;
        wr_color = cur_c_q;
        if (wr_ready) begin
          last_x_d[idx_q]     = cur_x_q;
          last_y_d[idx_q]     = cur_y_q;
          last_valid_d[idx_q] = 1'b1;
          state_d             = DONE;
        end
      end
      DONE: begin
        grant = done_onehot;
        ptr_d = (idx_q == PTR_W'(N_OBJ - 1)) ? '0 : idx_q + PTR_W'(1);
        // The granted object still holds req this cycle, so exclude it
        state_d = (vblank && (|(req & ~done_onehot))) ? PICK : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q      <= IDLE;
      ptr_q        <= '0;
      idx_q        <= '0;
      cur_x_q      <= '0;
      cur_y_q      <= '0;
      cur_c_q      <= '0;
      last_valid_q <= '0;
      vblank_q     <= 1'b0;
      step_en_q    <= 1'b0;
      for (int i = 0; i < N_OBJ; i++) begin
        last_x_q[i] <= '0;
        last_y_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      idx_q        <= idx_d;
      cur_x_q      <= cur_x_d;
      cur_y_q      <= cur_y_d;
      cur_c_q      <= cur_c_d;
      last_x_q     <= last_x_d;
      last_y_q     <= last_y_d;
      last_valid_q <= last_valid_d;
      vblank_q     <= vblank_d;
      step_en_q    <= step_en_d;
    end
  end

  assign step_en = step_en_q;
  assign busy    = (state_q != IDLE);

`ifdef OVERRUN_CNT_EN
  logic [7:0] overrun_q, overrun_d;

  always_comb begin
    overrun_d = overrun_q;
    if (!vblank && vblank_q && (|req) && (overrun_q != 8'hFF)) begin
      overrun_d = overrun_q + 8'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      overrun_q <= '0;
    end else begin
      overrun_q <= overrun_d;
    end
  end

  assign overrun_cnt = overrun_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_orbit_frame_scheduler.sv
`default_nettype none
// Bench for orbit_frame_scheduler: transaction-level model of expected writes
// and grants, checked every cycle, plus hand-computed literal expectations.
module tb_orbit_frame_scheduler;

  localparam int N  = 4;
  localparam int XW = 10;
  localparam int YW = 9;
  localparam int CW = 8;

  logic            clock = 1'b0;
  logic            reset = 1'b0;
  logic            vblank = 1'b0;
  logic            wr_ready = 1'b1;
  logic [N-1:0]    req = '0;
  logic [N*XW-1:0] req_x = '0;
  logic [N*YW-1:0] req_y = '0;
  logic [N*CW-1:0] req_color = '0;
  logic            step_en, wr_en, busy;
  logic [N-1:0]    grant;
  logic [XW-1:0]   wr_x;
  logic [YW-1:0]   wr_y;
  logic [CW-1:0]   wr_color;
`ifdef OVERRUN_CNT_EN
  logic [7:0]      overrun_cnt;
`endif

  orbit_frame_scheduler #(
    .N_OBJ(N), .X_W(XW), .Y_W(YW), .COLOR_W(CW)
  ) dut (
    .clock(clock), .reset(reset), .vblank(vblank), .step_en(step_en),
    .req(req), .req_x(req_x), .req_y(req_y), .req_color(req_color),
    .grant(grant), .wr_en(wr_en), .wr_ready(wr_ready),
    .wr_x(wr_x), .wr_y(wr_y), .wr_color(wr_color), .busy(busy)
`ifdef OVERRUN_CNT_EN
    , .overrun_cnt(overrun_cnt)
`endif
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic [CW-1:0] c;
  } wr_t;

  int   n_pass = 0;
  int   n_chk  = 0;
  int   n_wr   = 0;
  wr_t  exp_wr[$];
  wr_t  wr_log[$];
  int   exp_gnt[$];
  int   gnt_log[$];

  // model of the scheduler's observable memory
  int   m_ptr = 0;
  bit   m_valid[N];
  bit   m_pend[N];
  int   m_lx[N], m_ly[N];
  int   ox[N], oy[N], oc[N];

  logic [1:0]   vb_h = '0;
  logic [1:0]   rs_h = '0;
  logic [N-1:0] last_req = '0;
  bit           allow_drop = 1'b1;
  bit           rdy_tog = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, want %0h", name, act, exp);
  endtask

  task automatic model_reset();
    exp_wr.delete();
    exp_gnt.delete();
    m_ptr = 0;
    for (int i = 0; i < N; i++) begin
      m_valid[i] = 1'b0;
      m_pend[i]  = 1'b0;
    end
  endtask

  task automatic set_obj(input int i, input int x, input int y, input int c);
    ox[i] = x; oy[i] = y; oc[i] = c;
    req_x[i*XW +: XW]     = XW'(x);
    req_y[i*YW +: YW]     = YW'(y);
    req_color[i*CW +: CW] = CW'(c);
    req[i]    = 1'b1;
    m_pend[i] = 1'b1;
  endtask

  // Serve the next n pending objects in round-robin order from the model pointer
  task automatic model_serve_n(input int n);
    int k;
    for (int s = 0; s < n; s++) begin
      k = -1;
      for (int d = 0; d < N; d++)
        if (k < 0 && m_pend[(m_ptr + d) % N]) k = (m_ptr + d) % N;
      if (k >= 0) begin
        if (m_valid[k] && (m_lx[k] != ox[k] || m_ly[k] != oy[k]))
          exp_wr.push_back(wr_t'({XW'(m_lx[k]), YW'(m_ly[k]), CW'(0)}));
        exp_wr.push_back(wr_t'({XW'(ox[k]), YW'(oy[k]), CW'(oc[k])}));
        m_lx[k] = ox[k]; m_ly[k] = oy[k]; m_valid[k] = 1'b1;
        exp_gnt.push_back(k);
        m_pend[k] = 1'b0;
        m_ptr = (k + 1) % N;
      end
    end
  endtask

  // One clock: inputs are final on entry; outputs checked at the next negedge.
  task automatic cyc();
    wr_t  acc_w;
    wr_t  w;
    logic accept, stall;
    int   gi;
    if (!allow_drop && reset)
      chk("req_held_until_grant", 32'(last_req & ~req & ~grant), 0);
    last_req = req;
    accept = wr_en && wr_ready;
    stall  = wr_en && !wr_ready;
    acc_w  = {wr_x, wr_y, wr_color};
    vb_h   = {vb_h[0], vblank};
    rs_h   = {rs_h[0], reset};
    @(negedge clock);
    w = {wr_x, wr_y, wr_color};
    if (accept) begin
      n_wr++;
      wr_log.push_back(acc_w);
      chk("write_expected", 32'(exp_wr.size() > 0), 1);
      if (exp_wr.size() > 0) chk("write_data", 32'(acc_w), 32'(exp_wr.pop_front()));
    end
    if (stall && rs_h[0]) begin
      chk("stall_wr_en", 32'(wr_en), 1);
      chk("stall_wr_hold", 32'(w), 32'(acc_w));
    end
    if (&rs_h) chk("step_en", 32'(step_en), 32'(vb_h[0] && !vb_h[1]));
    if (grant != '0) begin
      gi = 0;
      for (int i = 0; i < N; i++) if (grant[i]) gi = i;
      gnt_log.push_back(gi);
      chk("grant_onehot", 32'($onehot(grant)), 1);
      chk("grant_expected", 32'(exp_gnt.size() > 0), 1);
      if (exp_gnt.size() > 0) chk("grant_idx", 32'(gi), 32'(exp_gnt.pop_front()));
    end
    #1;
    if (grant != '0) req = req & ~grant;
    if (rdy_tog) wr_ready = ~wr_ready;
  endtask

  task automatic run_frame(input int bound, output int lat);
    int t;
    int start;
    t = 0; start = -1; lat = -1;
    vblank = 1'b1;
    do begin
      cyc();
      t++;
      if (busy && start < 0) start = t;
      if (grant != '0 && lat < 0 && start >= 0) lat = t - start + 1;
    end while (!(t > 2 && !busy && exp_wr.size() == 0 && exp_gnt.size() == 0) && t < bound);
    chk("frame_within_bound", 32'(t < bound), 1);
    vblank = 1'b0;
    cyc();
    cyc();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int w0;
    int g0;
    int t;

    model_reset();
    reset = 1'b0;
    repeat (3) cyc();
    chk("reset_wr_en", 32'(wr_en), 0);
    chk("reset_busy", 32'(busy), 0);
    chk("reset_grant", 32'(grant), 0);
    chk("reset_step_en", 32'(step_en), 0);
    reset = 1'b1;
    cyc();
    allow_drop = 1'b0;

    // Reset while stalled in DRAW abandons the write
    wr_ready = 1'b0;
    set_obj(0, 10, 20, 8'hAA);
    vblank = 1'b1;
    t = 0;
    do begin cyc(); t++; end while (!wr_en && t < 20);
    chk("t1_draw_cycle", 32'(t), 2);
    chk("t1_draw_x", 32'(wr_x), 10);
    chk("t1_draw_color", 32'(wr_color), 32'h0AA);
    allow_drop = 1'b1;
    reset = 1'b0; vblank = 1'b0; req = '0;
    cyc();
    chk("t1_rst_wr_en", 32'(wr_en), 0);
    chk("t1_rst_grant", 32'(grant), 0);
    chk("t1_rst_busy", 32'(busy), 0);
    cyc(); cyc();
    reset = 1'b1;
    model_reset();
    wr_ready = 1'b1;
    cyc(); cyc();
    allow_drop = 1'b0;

    // First draw after reset: no erase
    set_obj(0, 100, 50, 8'hFF);
    model_serve_n(1);
    w0 = n_wr;
    run_frame(40, lat);
    chk("t2_latency", 32'(lat), 3);
    chk("t2_writes", 32'(n_wr - w0), 1);
    chk("t2_draw", 32'(wr_log[wr_log.size()-1]), 32'({10'd100, 9'd50, 8'hFF}));

    // Move: erase old then draw new
    set_obj(0, 101, 50, 8'hFF);
    model_serve_n(1);
    w0 = n_wr;
    run_frame(40, lat);
    chk("t3_latency_erase", 32'(lat), 4);
    chk("t3_writes_erase", 32'(n_wr - w0), 2);
    if (wr_log.size() >= 2)
      chk("t3_erase_data", 32'(wr_log[wr_log.size()-2]), 32'({10'd100, 9'd50, 8'h00}));

    // Same position: draw only
    set_obj(0, 101, 50, 8'hFF);
    model_serve_n(1);
    w0 = n_wr;
    run_frame(40, lat);
    chk("t3_latency_same", 32'(lat), 3);
    chk("t3_writes_same", 32'(n_wr - w0), 1);

    // Advance pointer to 2, then all four request together
    set_obj(1, 200, 100, 8'h11);
    model_serve_n(1);
    run_frame(40, lat);
    set_obj(0, 300, 200, 8'h21);
    set_obj(1, 310, 210, 8'h22);
    set_obj(2, 320, 220, 8'h23);
    set_obj(3, 330, 230, 8'h24);
    model_serve_n(4);
    g0 = gnt_log.size();
    run_frame(100, lat);
    chk("t4_grant_count", 32'(gnt_log.size() - g0), 4);
    if (gnt_log.size() - g0 == 4) begin
      chk("t4_order0", 32'(gnt_log[g0]), 2);
      chk("t4_order1", 32'(gnt_log[g0+1]), 3);
      chk("t4_order2", 32'(gnt_log[g0+2]), 0);
      chk("t4_order3", 32'(gnt_log[g0+3]), 1);
    end

    // vblank falls during obj1 erase with a toggling wr_ready
    set_obj(0, 400, 300, 8'h31);
    model_serve_n(1);
    run_frame(40, lat);
    set_obj(1, 410, 310, 8'h32);
    set_obj(2, 420, 320, 8'h33);
    model_serve_n(1);
    rdy_tog = 1'b1;
    vblank = 1'b1;
    t = 0;
    do begin cyc(); t++; end while (!(wr_en && wr_color == 8'h00) && t < 20);
    chk("t5_erase_seen", 32'(t < 20), 1);
    chk("t5_erase_x", 32'(wr_x), 310);
    vblank = 1'b0;
    t = 0;
    do begin cyc(); t++; end while ((busy || exp_wr.size() != 0 || exp_gnt.size() != 0) && t < 40);
    chk("t5_pair_done", 32'(t < 40), 1);
    rdy_tog = 1'b0;
    wr_ready = 1'b1;
    chk("t5_obj2_pending", 32'(req), 32'h4);
    repeat (5) cyc();
    chk("t5_no_new_pick", 32'(busy), 0);
    model_serve_n(1);
    run_frame(40, lat);
    chk("t5_obj2_granted", 32'(gnt_log[gnt_log.size()-1]), 2);

`ifdef OVERRUN_CNT_EN
    allow_drop = 1'b1;
    req = '0;
    reset = 1'b0;
    cyc(); cyc();
    reset = 1'b1;
    model_reset();
    cyc();
    chk("t6_overrun_reset", 32'(overrun_cnt), 0);
    allow_drop = 1'b0;
    wr_ready = 1'b0;
    set_obj(0, 5, 6, 8'h01);
    set_obj(1, 7, 8, 8'h02);
    for (int f = 0; f < 300; f++) begin
      vblank = 1'b1;
      cyc(); cyc();
      vblank = 1'b0;
      cyc(); cyc();
      if (f == 2) chk("t6_overrun_3", 32'(overrun_cnt), 3);
    end
    chk("t6_overrun_sat", 32'(overrun_cnt), 255);
    allow_drop = 1'b1;
    req = '0;
    reset = 1'b0;
    cyc(); cyc();
    reset = 1'b1;
    model_reset();
    wr_ready = 1'b1;
    cyc();
`endif

    chk("final_queues_empty", 32'(exp_wr.size() + exp_gnt.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
